// File: rtl/mbgd_pkg.sv
// mbgd_pkg: shared types and constants for the MBGD mini-batch sequencer.
//   mbgd_state_e  - sequencer FSM state, encoding is visible on the state port
//   MBGD_IDX_W    - default width of sample index / sample count / batch size
//   MBGD_EPOCH_W  - default width of epoch count / epoch counter
//   MBGD_STALL_W  - width of the optional stall counter (MBGD_STALL_CNT_EN)
package mbgd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FEED   = 2'b01,
        ST_UPDATE = 2'b10,
        ST_DONE   = 2'b11
    } mbgd_state_e;

    localparam int unsigned MBGD_IDX_W   = 8;
    localparam int unsigned MBGD_EPOCH_W = 8;
    localparam int unsigned MBGD_STALL_W = 16;

endpackage

// File: rtl/mbgd_seq_ctrl_iter_cnt.sv
// mbgd_iter_cnt: iteration counters for the MBGD sequencer.
// Ports:
//   apb_pclk, resetn      - clock, synchronous active-low reset
//   clear                 - zero every counter (legal start)
//   advance_sample        - a sample was transferred
//   close_batch           - the weight update for the closed batch completed
//   cfg_n, cfg_b, cfg_e   - latched samples/epoch, batch size, epoch count
//   sample_idx            - current sample index
//   batch_cnt, epoch_cnt  - batch within epoch, current epoch
//   last_in_batch         - current sample closes the batch
//   end_of_epoch          - current sample is the last of the epoch
//   last_epoch            - current epoch is the final one
module mbgd_iter_cnt
    import mbgd_pkg::*;
#(
    parameter int unsigned IDX_W   = MBGD_IDX_W,
    parameter int unsigned EPOCH_W = MBGD_EPOCH_W
) (
    input  logic               apb_pclk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               advance_sample,
    input  logic               close_batch,
    input  logic [IDX_W-1:0]   cfg_n,
    input  logic [IDX_W-1:0]   cfg_b,
    input  logic [EPOCH_W-1:0] cfg_e,
    output logic [IDX_W-1:0]   sample_idx,
    output logic [IDX_W-1:0]   batch_cnt,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               last_in_batch,
    output logic               end_of_epoch,
    output logic               last_epoch
);

    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [IDX_W-1:0]   inb_q,   inb_d;
    logic [IDX_W-1:0]   batch_q, batch_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    assign end_of_epoch  = (idx_q == cfg_n - IDX_W'(1));
    // A short final batch closes at the epoch end, not at B-1.
    assign last_in_batch = (inb_q == cfg_b - IDX_W'(1)) || end_of_epoch;
    assign last_epoch    = (epoch_q == cfg_e - EPOCH_W'(1));

    always_comb begin
        idx_d   = idx_q;
        inb_d   = inb_q;
        batch_d = batch_q;
        epoch_d = epoch_q;
        if (clear) begin
            idx_d   = '0;
            inb_d   = '0;
            batch_d = '0;
            epoch_d = '0;
        end else if (advance_sample) begin
            if (last_in_batch) begin
                inb_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
                inb_d = inb_q + IDX_W'(1);
            end
        end else if (close_batch) begin
            if (end_of_epoch) begin
                // Final batch of the final epoch: counters freeze for readback.
                if (!last_epoch) begin
                    epoch_d = epoch_q + EPOCH_W'(1);
                    batch_d = '0;
                    idx_d   = '0;
                end
            end else begin
                batch_d = batch_q + IDX_W'(1);
                idx_d   = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (!resetn) begin
            idx_q   <= '0;
            inb_q   <= '0;
            batch_q <= '0;
            epoch_q <= '0;
        end else begin
            idx_q   <= idx_d;
            inb_q   <= inb_d;
            batch_q <= batch_d;
            epoch_q <= epoch_d;
        end
    end

    assign sample_idx = idx_q;
    assign batch_cnt  = batch_q;
    assign epoch_cnt  = epoch_q;

endmodule

// File: rtl/mbgd_seq_ctrl.sv
// mbgd_seq_ctrl: mini-batch sequencer for the MBGD engine.
// Streams sample indices over valid/ready, requests one weight update per
// mini-batch, iterates over epochs and reports its FSM state.
// Ports:
//   apb_pclk, resetn          - clock, synchronous active-low reset
//   start, abort              - run request / cancel from the regfile
//   num_samples, batch_size,
//   num_epochs                - run configuration, latched on start
//   sample_valid/ready/idx    - sample stream handshake
//   last_in_batch             - qualifies sample_valid, closes the batch
//   update_req, update_ack    - weight update handshake
//   busy, done, err, state    - status (err sticky until next legal start)
//   epoch_cnt, batch_cnt      - progress counters
//   stall_cnt                 - only with MBGD_STALL_CNT_EN defined: saturating
//                               count of FEED/!ready and UPDATE/!ack cycles
module mbgd_seq_ctrl
    import mbgd_pkg::*;
#(
    parameter int unsigned IDX_W   = MBGD_IDX_W,
    parameter int unsigned EPOCH_W = MBGD_EPOCH_W
) (
    input  logic               apb_pclk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W-1:0]   num_samples,
    input  logic [IDX_W-1:0]   batch_size,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               last_in_batch,
    output logic               update_req,
    input  logic               update_ack,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         state,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [IDX_W-1:0]   batch_cnt
`ifdef MBGD_STALL_CNT_EN
    ,
    output logic [MBGD_STALL_W-1:0] stall_cnt
`endif
);

    mbgd_state_e        state_q, state_d;
    logic               err_q,   err_d;
    logic [IDX_W-1:0]   n_q,     n_d;
    logic [IDX_W-1:0]   b_q,     b_d;
    logic [EPOCH_W-1:0] e_q,     e_d;

    logic cnt_clear;
    logic cnt_adv;
    logic cnt_close;
    logic cnt_last;
    logic cnt_eoe;
    logic cnt_last_ep;
    logic start_go;
    logic cfg_legal;

    // abort beats start in IDLE.
    assign start_go  = (state_q == ST_IDLE) && start && !abort;
    assign cfg_legal = (num_samples != '0) && (batch_size != '0) && (num_epochs != '0);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        n_d       = n_q;
        b_d       = b_q;
        e_d       = e_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        cnt_close = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    n_d = num_samples;
                    b_d = batch_size;
                    e_d = num_epochs;
                    if (cfg_legal) begin
                        err_d     = 1'b0;
                        cnt_clear = 1'b1;
                        state_d   = ST_FEED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FEED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample_ready) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (update_ack) begin
                    cnt_close = 1'b1;
                    state_d   = (cnt_eoe && cnt_last_ep) ? ST_DONE : ST_FEED;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            n_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            n_q     <= n_d;
            b_q     <= b_d;
            e_q     <= e_d;
        end
    end

    mbgd_iter_cnt #(
        .IDX_W   (IDX_W),
        .EPOCH_W (EPOCH_W)
    ) u_iter_cnt (
        .apb_pclk       (apb_pclk),
        .resetn         (resetn),
        .clear          (cnt_clear),
        .advance_sample (cnt_adv),
        .close_batch    (cnt_close),
        .cfg_n          (n_q),
        .cfg_b          (b_q),
        .cfg_e          (e_q),
        .sample_idx     (sample_idx),
        .batch_cnt      (batch_cnt),
        .epoch_cnt      (epoch_cnt),
        .last_in_batch  (cnt_last),
        .end_of_epoch   (cnt_eoe),
        .last_epoch     (cnt_last_ep)
    );

    assign sample_valid  = (state_q == ST_FEED);
    assign last_in_batch = sample_valid && cnt_last;
    assign update_req    = (state_q == ST_UPDATE);
    assign busy          = sample_valid || update_req;
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;
    assign state         = state_q;

`ifdef MBGD_STALL_CNT_EN
    logic [MBGD_STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_go && cfg_legal) begin
            stall_d = '0;
        end else if (((state_q == ST_FEED) && !sample_ready) ||
                     ((state_q == ST_UPDATE) && !update_ack)) begin
            if (stall_q != '1) stall_d = stall_q + MBGD_STALL_W'(1);
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (!resetn) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mbgd_seq_ctrl.sv
// tb_mbgd_seq_ctrl: self-checking bench for mbgd_seq_ctrl. Expected behaviour
// comes from a transfer list built from N/B/E (index, batch closure, batch
// and epoch of every sample), walked with random ready/ack timing.
module tb_mbgd_seq_ctrl;

    logic       apb_pclk;
    logic       resetn;
    logic       start;
    logic       abort;
    logic [7:0] num_samples;
    logic [7:0] batch_size;
    logic [7:0] num_epochs;
    logic       sample_valid;
    logic       sample_ready;
    logic [7:0] sample_idx;
    logic       last_in_batch;
    logic       update_req;
    logic       update_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state;
    logic [7:0] epoch_cnt;
    logic [7:0] batch_cnt;
`ifdef MBGD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        bit last;
        int batch;
        int epoch;
    } xfer_t;

    mbgd_seq_ctrl dut (
        .apb_pclk      (apb_pclk),
        .resetn        (resetn),
        .start         (start),
        .abort         (abort),
        .num_samples   (num_samples),
        .batch_size    (batch_size),
        .num_epochs    (num_epochs),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_idx    (sample_idx),
        .last_in_batch (last_in_batch),
        .update_req    (update_req),
        .update_ack    (update_ack),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .state         (state),
        .epoch_cnt     (epoch_cnt),
        .batch_cnt     (batch_cnt)
`ifdef MBGD_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial apb_pclk = 1'b0;
    always #5 apb_pclk = ~apb_pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".state"}, 32'(state), 0);
        check({tag, ".valid"}, 32'(sample_valid), 0);
        check({tag, ".idx"}, 32'(sample_idx), 0);
        check({tag, ".last"}, 32'(last_in_batch), 0);
        check({tag, ".req"}, 32'(update_req), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".err"}, 32'(err), 0);
        check({tag, ".epoch"}, 32'(epoch_cnt), 0);
        check({tag, ".batch"}, 32'(batch_cnt), 0);
    endtask

    // Full run: rnd=0 gives ready=1 and ack two cycles after each request.
    task automatic run(input int n, input int b, input int e, input bit rnd);
        xfer_t q[$];
        int    ptr;
        bit    in_upd;
        bit    finished;
        int    wait_cnt;
        int    cb;
        int    ce;
        int    cyc;
        for (int ep = 0; ep < e; ep++)
            for (int s = 0; s < n; s++)
                q.push_back('{s, ((s % b) == b - 1) || (s == n - 1), s / b, ep});
        ptr = 0; in_upd = 0; finished = 0; wait_cnt = 0; cb = 0; ce = 0; cyc = 0;
        num_samples  = 8'(n);
        batch_size   = 8'(b);
        num_epochs   = 8'(e);
        start        = 1'b1;
        sample_ready = 1'b0;
        update_ack   = 1'b0;
        @(negedge apb_pclk);
        start = 1'b0;
        check("run.err_cleared", 32'(err), 0);
        while (!finished && cyc < 4000) begin
            cyc++;
            if (!in_upd) begin
                check("feed.state", 32'(state), 1);
                check("feed.valid", 32'(sample_valid), 1);
                check("feed.busy", 32'(busy), 1);
                check("feed.req", 32'(update_req), 0);
                check("feed.idx", 32'(sample_idx), 32'(q[ptr].idx));
                check("feed.last", 32'(last_in_batch), 32'(q[ptr].last));
                check("feed.batch", 32'(batch_cnt), 32'(q[ptr].batch));
                check("feed.epoch", 32'(epoch_cnt), 32'(q[ptr].epoch));
                sample_ready = rnd ? 1'(($urandom % 4) != 0) : 1'b1;
                update_ack   = rnd ? 1'($urandom % 2) : 1'b0;
                if (sample_ready) begin
                    if (q[ptr].last) begin
                        in_upd   = 1;
                        wait_cnt = rnd ? int'($urandom % 4) : 2;
                        cb       = q[ptr].batch;
                        ce       = q[ptr].epoch;
                    end
                    ptr++;
                end
            end else begin
                check("upd.state", 32'(state), 2);
                check("upd.valid", 32'(sample_valid), 0);
                check("upd.req", 32'(update_req), 1);
                check("upd.busy", 32'(busy), 1);
                check("upd.batch", 32'(batch_cnt), 32'(cb));
                check("upd.epoch", 32'(epoch_cnt), 32'(ce));
                sample_ready = rnd ? 1'($urandom % 2) : 1'b1;
                if (wait_cnt == 0) begin
                    update_ack = 1'b1;
                    in_upd     = 0;
                    if (ptr == q.size()) finished = 1;
                end else begin
                    update_ack = 1'b0;
                    wait_cnt--;
                end
            end
            if (rnd) begin
                start       = 1'(($urandom % 8) == 0);
                num_samples = 8'($urandom);
                batch_size  = 8'($urandom);
                num_epochs  = 8'($urandom);
            end
            @(negedge apb_pclk);
        end
        check("run.completed_in_budget", 32'(finished), 1);
        start        = 1'b0;
        update_ack   = 1'b0;
        sample_ready = 1'b0;
        check("done.state", 32'(state), 3);
        check("done.pulse", 32'(done), 1);
        check("done.busy", 32'(busy), 0);
        check("done.req", 32'(update_req), 0);
        @(negedge apb_pclk);
        check("end.state", 32'(state), 0);
        check("end.done", 32'(done), 0);
        check("end.idx", 32'(sample_idx), 32'(n - 1));
        check("end.batch", 32'(batch_cnt), 32'((n - 1) / b));
        check("end.epoch", 32'(epoch_cnt), 32'(e - 1));
        check("end.err", 32'(err), 0);
    endtask

    initial begin
        int k;
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        num_samples = '0; batch_size = '0; num_epochs = '0;
        sample_ready = 1'b0; update_ack = 1'b0;
        @(negedge apb_pclk);
        @(negedge apb_pclk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge apb_pclk);

        // Partial final batch, then epoch wrap.
        run(5, 2, 1, 0);
        run(4, 4, 3, 0);

        // Backpressure at idx 1.
        num_samples = 8'd3; batch_size = 8'd3; num_epochs = 8'd1;
        start = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0; sample_ready = 1'b1;
        @(negedge apb_pclk);
        check("bp.idx_before", 32'(sample_idx), 1);
        sample_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge apb_pclk);
            check("bp.valid", 32'(sample_valid), 1);
            check("bp.idx", 32'(sample_idx), 1);
            check("bp.last", 32'(last_in_batch), 0);
        end
`ifdef MBGD_STALL_CNT_EN
        check("bp.stall_cnt", 32'(stall_cnt), 5);
`endif
        sample_ready = 1'b1;
        k = 0;
        while (!update_req && k < 20) begin
            @(negedge apb_pclk);
            k++;
        end
        check("bp.reached_update", 32'(update_req), 1);
        check("bp.idx_at_update", 32'(sample_idx), 2);
        update_ack = 1'b1;
        @(negedge apb_pclk);
        update_ack = 1'b0;
        check("bp.done", 32'(done), 1);
        @(negedge apb_pclk);

        // Config errors, then a legal start clears err.
        num_samples = 8'd4; batch_size = 8'd0; num_epochs = 8'd1;
        start = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0;
        check("cfg.err_b0", 32'(err), 1);
        check("cfg.state", 32'(state), 0);
        check("cfg.busy", 32'(busy), 0);
        check("cfg.valid", 32'(sample_valid), 0);
        num_samples = 8'd0; batch_size = 8'd2;
        start = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0;
        check("cfg.err_n0", 32'(err), 1);
        num_samples = 8'd4; num_epochs = 8'd0;
        start = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0;
        check("cfg.err_e0", 32'(err), 1);
        @(negedge apb_pclk);
        check("cfg.err_sticky", 32'(err), 1);
        run(4, 2, 1, 0);

        // start together with abort in IDLE: no run.
        num_samples = 8'd4; batch_size = 8'd2; num_epochs = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0; abort = 1'b0;
        check("sa.state", 32'(state), 0);
        check("sa.valid", 32'(sample_valid), 0);

        // Abort in UPDATE coincident with ack.
        start = 1'b1; sample_ready = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0;
        k = 0;
        while (!update_req && k < 20) begin
            @(negedge apb_pclk);
            k++;
        end
        check("ab.reached_update", 32'(update_req), 1);
        update_ack = 1'b1; abort = 1'b1;
        @(negedge apb_pclk);
        update_ack = 1'b0; abort = 1'b0; sample_ready = 1'b0;
        check("ab.state", 32'(state), 0);
        check("ab.req", 32'(update_req), 0);
        check("ab.done", 32'(done), 0);
        check("ab.batch", 32'(batch_cnt), 0);
        check("ab.idx", 32'(sample_idx), 1);
        check("ab.epoch", 32'(epoch_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge apb_pclk);
            check("ab.no_done", 32'(done), 0);
            check("ab.idle", 32'(state), 0);
        end

        // Synchronous reset mid-FEED.
        num_samples = 8'd6; batch_size = 8'd3; num_epochs = 8'd1;
        start = 1'b1; sample_ready = 1'b1;
        @(negedge apb_pclk);
        start = 1'b0;
        @(negedge apb_pclk);
        check("rst.mid_feed", 32'(sample_idx), 1);
        resetn = 1'b0;
        @(negedge apb_pclk);
        resetn = 1'b1; sample_ready = 1'b0;
        check_all_zero("rst.mid");
        @(negedge apb_pclk);
        check("rst.no_done", 32'(done), 0);
        run(6, 3, 1, 0);

        // Boundaries and random timing.
        run(1, 1, 1, 1);
        run(3, 5, 2, 1);
        for (int r = 0; r < 6; r++)
            run(1 + int'($urandom % 9), 1 + int'($urandom % 4), 1 + int'($urandom % 3), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
